mem_resp_wb: RTL and testbench
==============================

Name: mem_resp_wb

Overview:
- Sits directly downstream of the Memory stage in the 5-stage MIPS pipeline.
- Tracks the data-bus transaction that the Memory stage issues and stalls the pipeline until the response arrives.
- Extracts and extends load data, then registers the M→W boundary.
- Drives the register-file write port: write enable, destination and data.

Parameters:
- none; all widths are fixed by the shared MIPS package (word_t = 32 bits, register index = 5 bits, opcode/funct = 6 bits).

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- m_valid  in  1  Memory-stage slot holds a real instruction
- m_opcode  in  6  instruction opcode
- m_funct  in  6  R-type funct field
- m_btype  in  5  branch subtype (rt field)
- m_valE  in  32  ALU result / effective address (bits [1:0] give the byte offset)
- m_dstE  in  5  ALU destination register
- m_dstM  in  5  load destination register
- m_pc  in  32  instruction PC
- dreq_valid  in  1  Memory stage is issuing a bus request this cycle
- dresp_addr_ok  in  1  bus accepted the address
- dresp_data_ok  in  1  bus completed the access
- dresp_data  in  32  aligned read word
- req_mask  out  1  suppress dreq.valid (address already accepted)
- stall  out  1  freeze PC, F/D/E/M registers
- wb_valid  out  1  W-stage slot valid
- wb_we  out  1  register-file write enable
- wb_dst  out  5  write register
- wb_data  out  32  write data
- wb_pc  out  32  PC of retiring instruction

Behaviour:
- Reset (asynchronous, any state): state=IDLE; wb_valid, wb_we, wb_dst, wb_data, wb_pc all 0. req_mask=0 and stall=0 in IDLE with no request.
- A mem op is present when m_valid & dreq_valid (loads LW/LB/LH/LBU/LHU and stores SW/SB/SH).
- FSM states: IDLE, WAIT_ADDR, WAIT_DATA.
- IDLE, mem op present:
  - addr_ok & data_ok → complete this cycle, stay in IDLE.
  - addr_ok only → WAIT_DATA.
  - neither → WAIT_ADDR.
- WAIT_ADDR:
  - addr_ok & data_ok → complete, go to IDLE.
  - addr_ok only → WAIT_DATA.
  - else stay.
- WAIT_DATA:
  - req_mask=1 so the request is not re-issued.
  - data_ok → complete, go to IDLE.
  - addr_ok in this state is ignored.
- stall (combinational) = mem op present & not completing this cycle.
- Stores wait for data_ok exactly like loads.
- W register load rule (clock edge):
  - Completion cycle, or non-mem op with m_valid: load the W register.
  - stall=1: load a bubble (wb_valid=0, wb_we=0).
  - m_valid=0: load a bubble.
- Latency: one cycle from completion (or from m_valid for non-mem ops) to wb_valid.
- Load data (offset o = m_valE[1:0], sampled while stalled; upstream holds it stable):
  - LW: data.
  - LB / LBU: byte at data[8o+7:8o], sign- / zero-extended.
  - LH / LHU: half at data[16·o[1]+15:16·o[1]], sign- / zero-extended.
- Write-enable and destination:
  - Loads: wb_we=1, wb_dst=m_dstM.
  - R-type (excluding JR/MULT/MULTU/DIV/DIVU/MTHI/MTLO), LUI, SLTI, SLTIU, ADDIU, ANDI, ORI, XORI, JAL, and BLTZAL/BGEZAL: wb_we=1, wb_dst=m_dstE, wb_data=m_valE.
  - Stores, branches, all others: wb_we=0.
- Destination $0: wb_we forced to 0 whenever wb_dst=0.
- Stray responses: data_ok in IDLE with no mem op present (e.g. a late response after reset) is ignored; no W update, no stall.
- Misaligned LW/LH addresses are not checked here; the block does not raise an exception.

Decomposition:
- Shared package (with the existing pipeline typedefs): opcode/funct/btype constants, the FSM state enum, and a plr_w-compatible W record.
- One natural sub-module, load_extend: combinational opcode + offset + word → 32-bit extended result.

Test Plan:
- ADDIU, valE=0x0000_1234, dstE=5 → next cycle wb_valid=1, wb_we=1, wb_dst=5, wb_data=0x1234; stall never asserted.
- LB, valE=0x...0003, dstM=8; addr_ok cycle 1, data_ok cycle 3 with data=0x80FF_0000:
  - stall=1 for cycles 0–2; req_mask=1 in cycles 2–3.
  - Cycle 4: wb_data=0xFFFF_FF80, wb_dst=8.
- LHU, offset 2, addr_ok & data_ok same cycle, data=0xBEEF_0001 → no stall; next cycle wb_data=0x0000_BEEF.
- SW with data_ok 2 cycles after addr_ok → stall held until data_ok; then wb_valid=1, wb_we=0.
- ORI with dstE=0 → wb_we=0; separately, a lone data_ok pulse in IDLE → no stall, W register unchanged.
- resetn dropped during WAIT_DATA → immediately state=IDLE, all outputs 0; data_ok arriving after release is ignored.

Source files
------------

// File: rtl/mem_resp_wb_pkg.sv
// rtl/mem_resp_wb_pkg.sv - shared MIPS types, opcode constants, FSM states and W record
package mem_resp_wb_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_idx_t;
  typedef logic [5:0]  op_t;

  localparam op_t OP_SPECIAL = 6'h00;
  localparam op_t OP_REGIMM  = 6'h01;
  localparam op_t OP_JAL     = 6'h03;
  localparam op_t OP_ADDIU   = 6'h09;
  localparam op_t OP_SLTI    = 6'h0A;
  localparam op_t OP_SLTIU   = 6'h0B;
  localparam op_t OP_ANDI    = 6'h0C;
  localparam op_t OP_ORI     = 6'h0D;
  localparam op_t OP_XORI    = 6'h0E;
  localparam op_t OP_LUI     = 6'h0F;
  localparam op_t OP_LB      = 6'h20;
  localparam op_t OP_LH      = 6'h21;
  localparam op_t OP_LW      = 6'h23;
  localparam op_t OP_LBU     = 6'h24;
  localparam op_t OP_LHU     = 6'h25;
  localparam op_t OP_SB      = 6'h28;
  localparam op_t OP_SH      = 6'h29;
  localparam op_t OP_SW      = 6'h2B;

  localparam op_t FN_JR    = 6'h08;
  localparam op_t FN_MTHI  = 6'h11;
  localparam op_t FN_MTLO  = 6'h13;
  localparam op_t FN_MULT  = 6'h18;
  localparam op_t FN_MULTU = 6'h19;
  localparam op_t FN_DIV   = 6'h1A;
  localparam op_t FN_DIVU  = 6'h1B;

  localparam reg_idx_t BT_BLTZAL = 5'h10;
  localparam reg_idx_t BT_BGEZAL = 5'h11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ADDR,
    ST_WAIT_DATA
  } mem_state_e;

  typedef struct packed {
    logic     valid;
    logic     we;
    reg_idx_t dst;
    word_t    data;
    word_t    pc;
  } plr_w_t;

  function automatic logic is_load(input op_t op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LH) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/mem_resp_wb_load_extend.sv
// rtl/mem_resp_wb_load_extend.sv - selects and extends load data by opcode and byte offset
module mem_resp_wb_load_extend
  import mem_resp_wb_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  offset,
  input  logic [31:0] data_word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data_word[7:0];
    case (offset)
      2'd1:    byte_sel = data_word[15:8];
      2'd2:    byte_sel = data_word[23:16];
      2'd3:    byte_sel = data_word[31:24];
      default: byte_sel = data_word[7:0];
    endcase
    half_sel = offset[1] ? data_word[31:16] : data_word[15:0];

    result = data_word;
    case (opcode)
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'h0, byte_sel};
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'h0, half_sel};
      default: result = data_word;
    endcase
  end

endmodule

// File: rtl/mem_resp_wb.sv
// rtl/mem_resp_wb.sv - data-bus response tracker, stall generation and M->W writeback register
module mem_resp_wb
  import mem_resp_wb_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        m_valid,
  input  logic [5:0]  m_opcode,
  input  logic [5:0]  m_funct,
  input  logic [4:0]  m_btype,
  input  logic [31:0] m_valE,
  input  logic [4:0]  m_dstE,
  input  logic [4:0]  m_dstM,
  input  logic [31:0] m_pc,
  input  logic        dreq_valid,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        req_mask,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_dst,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc
);

  mem_state_e state_q, state_d;
  plr_w_t     w_q, w_d;
  logic       mem_op, busy, complete, writer;
  word_t      load_data;

  mem_resp_wb_load_extend u_load_extend (
    .opcode    (m_opcode),
    .offset    (m_valE[1:0]),
    .data_word (dresp_data),
    .result    (load_data)
  );

  assign mem_op = m_valid & dreq_valid;
  // Once waiting, the held M slot is the pending access even if dreq_valid is masked.
  assign busy   = mem_op | (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    req_mask = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          complete = dresp_addr_ok & dresp_data_ok;
          if (dresp_addr_ok && !dresp_data_ok) state_d = ST_WAIT_DATA;
          else if (!dresp_addr_ok)             state_d = ST_WAIT_ADDR;
        end
      end
      ST_WAIT_ADDR: begin
        complete = dresp_addr_ok & dresp_data_ok;
        if (complete)           state_d = ST_IDLE;
        else if (dresp_addr_ok) state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        req_mask = 1'b1;
        complete = dresp_data_ok;
        if (complete) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    stall = busy & ~complete;
  end

  always_comb begin
    writer = 1'b0;
    case (m_opcode)
      OP_SPECIAL: writer = !(m_funct inside {FN_JR, FN_MULT, FN_MULTU, FN_DIV,
                                             FN_DIVU, FN_MTHI, FN_MTLO});
      OP_REGIMM:  writer = (m_btype == BT_BLTZAL) || (m_btype == BT_BGEZAL);
      OP_LUI, OP_SLTI, OP_SLTIU, OP_ADDIU, OP_ANDI,
      OP_ORI, OP_XORI, OP_JAL: writer = 1'b1;
      default:    writer = 1'b0;
    endcase
  end

  // Bubbles clear only valid/we; dst/data/pc keep their last contents.
  always_comb begin
    w_d       = w_q;
    w_d.valid = 1'b0;
    w_d.we    = 1'b0;
    if (m_valid && (!busy || complete)) begin
      w_d.valid = 1'b1;
      w_d.pc    = m_pc;
      if (is_load(m_opcode)) begin
        w_d.we   = 1'b1;
        w_d.dst  = m_dstM;
        w_d.data = load_data;
      end else begin
        w_d.we   = writer;
        w_d.dst  = m_dstE;
        w_d.data = m_valE;
      end
      if (w_d.dst == 5'd0) w_d.we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
    end
  end

  assign wb_valid = w_q.valid;
  assign wb_we    = w_q.we;
  assign wb_dst   = w_q.dst;
  assign wb_data  = w_q.data;
  assign wb_pc    = w_q.pc;

endmodule

// File: tb/tb_mem_resp_wb.sv
// tb/tb_mem_resp_wb.sv - directed self-checking bench for mem_resp_wb
module tb_mem_resp_wb;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m_valid;
  logic [5:0]  m_opcode, m_funct;
  logic [4:0]  m_btype, m_dstE, m_dstM;
  logic [31:0] m_valE, m_pc;
  logic        dreq_valid, dresp_addr_ok, dresp_data_ok;
  logic [31:0] dresp_data;
  logic        req_mask, stall, wb_valid, wb_we;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data, wb_pc;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_resp_wb dut (
    .clk(clk), .resetn(resetn), .m_valid(m_valid), .m_opcode(m_opcode),
    .m_funct(m_funct), .m_btype(m_btype), .m_valE(m_valE), .m_dstE(m_dstE),
    .m_dstM(m_dstM), .m_pc(m_pc), .dreq_valid(dreq_valid),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data), .req_mask(req_mask), .stall(stall),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
    .wb_pc(wb_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    m_valid = 0; dreq_valid = 0; dresp_addr_ok = 0; dresp_data_ok = 0;
    m_opcode = 0; m_funct = 0; m_btype = 0; m_valE = 0; m_dstE = 0; m_dstM = 0;
    m_pc = 0; dresp_data = 0;
  endtask

  task automatic set_op(input logic [5:0] op, input logic [31:0] vale,
                        input logic [4:0] dste, input logic [4:0] dstm,
                        input logic [31:0] pc, input logic mem);
    m_valid = 1; m_opcode = op; m_funct = 0; m_btype = 0; m_valE = vale;
    m_dstE = dste; m_dstM = dstm; m_pc = pc; dreq_valid = mem;
  endtask

  initial begin
    resetn = 0;
    go_idle();
    #12;
    chk("rst_valid", {31'b0, wb_valid}, 0);
    chk("rst_we", {31'b0, wb_we}, 0);
    chk("rst_dst", {27'b0, wb_dst}, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_pc", wb_pc, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_mask", {31'b0, req_mask}, 0);
    @(posedge clk); #1 resetn = 1;

    // ADDIU
    set_op(6'h09, 32'h0000_1234, 5'd5, 5'd0, 32'h100, 0);
    #1 chk("addiu_stall", {31'b0, stall}, 0);
    tick(); go_idle();
    chk("addiu_valid", {31'b0, wb_valid}, 1);
    chk("addiu_we", {31'b0, wb_we}, 1);
    chk("addiu_dst", {27'b0, wb_dst}, 5);
    chk("addiu_data", wb_data, 32'h1234);
    chk("addiu_pc", wb_pc, 32'h100);

    // LB offset 3, addr_ok in cycle 1, data_ok in cycle 3
    set_op(6'h20, 32'h0000_1003, 5'd0, 5'd8, 32'h104, 1);
    #1 chk("lb_c0_stall", {31'b0, stall}, 1);
    chk("lb_c0_mask", {31'b0, req_mask}, 0);
    tick();
    dresp_addr_ok = 1;
    #1 chk("lb_c1_stall", {31'b0, stall}, 1);
    chk("lb_c1_bubble", {31'b0, wb_valid}, 0);
    tick(); dresp_addr_ok = 0;
    #1 chk("lb_c2_stall", {31'b0, stall}, 1);
    chk("lb_c2_mask", {31'b0, req_mask}, 1);
    tick();
    dresp_data_ok = 1; dresp_data = 32'h80FF_0000;
    #1 chk("lb_c3_stall", {31'b0, stall}, 0);
    chk("lb_c3_mask", {31'b0, req_mask}, 1);
    tick(); go_idle();
    chk("lb_valid", {31'b0, wb_valid}, 1);
    chk("lb_we", {31'b0, wb_we}, 1);
    chk("lb_dst", {27'b0, wb_dst}, 8);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_mask_idle", {31'b0, req_mask}, 0);

    // LHU offset 2, same-cycle response
    set_op(6'h25, 32'h0000_2002, 5'd0, 5'd9, 32'h108, 1);
    dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 32'hBEEF_0001;
    #1 chk("lhu_stall", {31'b0, stall}, 0);
    chk("lhu_mask", {31'b0, req_mask}, 0);
    tick(); go_idle();
    chk("lhu_data", wb_data, 32'h0000_BEEF);
    chk("lhu_dst", {27'b0, wb_dst}, 9);

    // LH offset 0 sign-extension, LBU offset 1 zero-extension
    set_op(6'h21, 32'h0000_3000, 5'd0, 5'd10, 32'h10C, 1);
    dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 32'h1234_8001;
    tick(); go_idle();
    chk("lh_data", wb_data, 32'hFFFF_8001);
    set_op(6'h24, 32'h0000_3001, 5'd0, 5'd11, 32'h110, 1);
    dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 32'h0000_9A00;
    tick(); go_idle();
    chk("lbu_data", wb_data, 32'h0000_009A);

    // SW, data_ok two cycles after addr_ok
    set_op(6'h2B, 32'h0000_4000, 5'd0, 5'd0, 32'h114, 1);
    dresp_addr_ok = 1;
    #1 chk("sw_c0_stall", {31'b0, stall}, 1);
    tick(); dresp_addr_ok = 0;
    #1 chk("sw_c1_stall", {31'b0, stall}, 1);
    tick(); dresp_data_ok = 1;
    #1 chk("sw_c2_stall", {31'b0, stall}, 0);
    tick(); go_idle();
    chk("sw_valid", {31'b0, wb_valid}, 1);
    chk("sw_we", {31'b0, wb_we}, 0);
    chk("sw_pc", wb_pc, 32'h114);

    // ORI to $0, then stray data_ok
    set_op(6'h0D, 32'h0000_00FF, 5'd0, 5'd0, 32'h118, 0);
    tick(); go_idle();
    chk("ori0_valid", {31'b0, wb_valid}, 1);
    chk("ori0_we", {31'b0, wb_we}, 0);
    dresp_data_ok = 1; dresp_data = 32'hDEAD_BEEF;
    #1 chk("stray_stall", {31'b0, stall}, 0);
    chk("stray_mask", {31'b0, req_mask}, 0);
    tick(); go_idle();
    chk("stray_valid", {31'b0, wb_valid}, 0);
    chk("stray_we", {31'b0, wb_we}, 0);
    chk("stray_data", wb_data, 32'h0000_00FF);

    // Async reset while in WAIT_DATA
    set_op(6'h23, 32'h0000_5000, 5'd0, 5'd12, 32'h11C, 1);
    dresp_addr_ok = 1;
    tick(); go_idle();
    #1 chk("wd_mask", {31'b0, req_mask}, 1);
    #2 resetn = 0;
    #1 chk("arst_mask", {31'b0, req_mask}, 0);
    chk("arst_stall", {31'b0, stall}, 0);
    chk("arst_valid", {31'b0, wb_valid}, 0);
    chk("arst_dst", {27'b0, wb_dst}, 0);
    chk("arst_data", wb_data, 0);
    chk("arst_pc", wb_pc, 0);
    @(posedge clk); #1 resetn = 1;
    dresp_data_ok = 1; dresp_data = 32'h1111_2222;
    #1 chk("late_stall", {31'b0, stall}, 0);
    tick(); go_idle();
    chk("late_valid", {31'b0, wb_valid}, 0);
    chk("late_data", wb_data, 0);
    chk("late_mask", {31'b0, req_mask}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
